// File: rtl/alu_mc.sv
// alu_mc: parametrised multi-cycle ALU for the execute stage.
//
// Single-cycle ops (ADD/AND/OR/XOR/SLL/SRL) finish one cycle after the
// accepting edge. MUL (shift-add) and DIV (restoring) run N iterations in
// the RUN state. Every result and flag is registered and holds until the
// next done pulse.
//
// Build option: define ALU_MC_DIV_EN to build the divider datapath. When it
// is undefined, op 111 is an illegal single-cycle op (Out=0, Ofl=1, DivZ=0).
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          request, sampled in IDLE or DONE only
//   InA, InB       operands (N bits)
//   Cin            carry-in (ADD only)
//   Op             opcode (O bits)
//   invA, invB     operand inversion (ADD/AND/OR/XOR only)
//   sign           signed interpretation
//   slbi           A replaced by InA << N/2
//   busy, done     RUN state / one-cycle result-valid pulse
//   Out            registered result
//   Zero           Out == 0
//   Ofl, Cout      overflow / ADD carry-out
//   DivZ           divide by zero
module alu_mc #(
  parameter int N = 16,
  parameter int O = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] InA,
  input  logic [N-1:0] InB,
  input  logic         Cin,
  input  logic [O-1:0] Op,
  input  logic         invA,
  input  logic         invB,
  input  logic         sign,
  input  logic         slbi,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Out,
  output logic         Zero,
  output logic         Ofl,
  output logic         Cout,
  output logic         DivZ
);

  localparam int LW = $clog2(N);

  localparam logic [O-1:0] OP_ADD = O'(3'd0);
  localparam logic [O-1:0] OP_AND = O'(3'd1);
  localparam logic [O-1:0] OP_OR  = O'(3'd2);
  localparam logic [O-1:0] OP_XOR = O'(3'd3);
  localparam logic [O-1:0] OP_SLL = O'(3'd4);
  localparam logic [O-1:0] OP_SRL = O'(3'd5);
  localparam logic [O-1:0] OP_MUL = O'(3'd6);
  localparam logic [O-1:0] OP_DIV = O'(3'd7);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;

  // Result registers
  logic [N-1:0] out_r;
  logic         ofl_r, cout_r, divz_r;

  // Iteration state
  logic [LW-1:0]  cnt_r;
  logic           sign_r, neg_r;
  logic [2*N-1:0] prod_r, mcand_r;
  logic [N-1:0]   mplier_r;

  // Operand conditioning and single-cycle results
  logic [N-1:0] a_s, a_op_s, b_op_s, mag_a_s, mag_b_s;
  logic [N:0]   sum_s;
  logic [LW-1:0] shamt_s;
  logic         a_neg_s, b_neg_s;
  logic [N-1:0] sc_out_s;
  logic         sc_ofl_s, sc_cout_s;
  logic         is_div_s, multi_s, accept_s;

  // Iteration step and final results
  logic [2*N-1:0] prod_nxt_s, mul_fin_s;
  logic           mul_ofl_s;
  logic [N-1:0]   fin_out_s;
  logic           fin_ofl_s, fin_divz_s;

`ifdef ALU_MC_DIV_EN
  logic [N-1:0] quo_r, rem_r, dvs_r;
  logic         is_div_r, dz_r, dofl_r;
  logic [N:0]   rem_sh_s;
  logic [N-1:0] rem_diff_s, rem_nxt_s, quo_nxt_s, div_fin_s;
  logic         ge_s;
`endif

  // Operand conditioning, single-cycle result and operation classification
  always_comb begin
    a_s       = slbi ? (InA << (N/2)) : InA;
    a_op_s    = invA ? ~a_s : a_s;
    b_op_s    = invB ? ~InB : InB;
    sum_s     = {1'b0, a_op_s} + {1'b0, b_op_s} + {{N{1'b0}}, Cin};
    shamt_s   = InB[LW-1:0];
    a_neg_s   = sign & a_s[N-1];
    b_neg_s   = sign & InB[N-1];
    mag_a_s   = a_neg_s ? ({N{1'b0}} - a_s) : a_s;
    mag_b_s   = b_neg_s ? ({N{1'b0}} - InB) : InB;
    sc_out_s  = {N{1'b0}};
    sc_ofl_s  = 1'b0;
    sc_cout_s = 1'b0;
    case (Op)
      OP_ADD: begin
        sc_out_s  = sum_s[N-1:0];
        sc_cout_s = sum_s[N];
        // Signed overflow: equal operand signs, different result sign
        sc_ofl_s  = sign ? ((a_op_s[N-1] == b_op_s[N-1]) && (sum_s[N-1] != a_op_s[N-1]))
                         : sum_s[N];
      end
      OP_AND: sc_out_s = a_op_s & b_op_s;
      OP_OR:  sc_out_s = a_op_s | b_op_s;
      OP_XOR: sc_out_s = a_op_s ^ b_op_s;
      OP_SLL: sc_out_s = a_s << shamt_s;
      OP_SRL: sc_out_s = sign ? $unsigned($signed(a_s) >>> shamt_s) : (a_s >> shamt_s);
      default: begin
        // Only an unbuilt DIV reaches here
        sc_out_s = {N{1'b0}};
        sc_ofl_s = 1'b1;
      end
    endcase
`ifdef ALU_MC_DIV_EN
    is_div_s = (Op == OP_DIV);
`else
    is_div_s = 1'b0;
`endif
    multi_s  = (Op == OP_MUL) | is_div_s;
    accept_s = start & ((state_r == S_IDLE) | (state_r == S_DONE));
  end

  // Multiplier step and final product with sign/overflow handling
  always_comb begin
    prod_nxt_s = mplier_r[0] ? (prod_r + mcand_r) : prod_r;
    mul_fin_s  = neg_r ? ({(2*N){1'b0}} - prod_nxt_s) : prod_nxt_s;
    // Signed fit: top N+1 bits all equal; unsigned fit: top N bits zero
    mul_ofl_s  = sign_r ? ~((&mul_fin_s[2*N-1:N-1]) | ~(|mul_fin_s[2*N-1:N-1]))
                        : (|mul_fin_s[2*N-1:N]);
  end

`ifdef ALU_MC_DIV_EN
  // Restoring divider step: shift in next dividend bit, subtract if it fits
  always_comb begin
    rem_sh_s   = {rem_r, quo_r[N-1]};
    ge_s       = (rem_sh_s >= {1'b0, dvs_r});
    rem_diff_s = rem_sh_s[N-1:0] - dvs_r;
    rem_nxt_s  = ge_s ? rem_diff_s : rem_sh_s[N-1:0];
    quo_nxt_s  = {quo_r[N-2:0], ge_s};
    div_fin_s  = dz_r ? {N{1'b1}} : (neg_r ? ({N{1'b0}} - quo_nxt_s) : quo_nxt_s);
  end
`endif

  // Select the multi-cycle result written on the last iteration
  always_comb begin
    fin_out_s  = mul_fin_s[N-1:0];
    fin_ofl_s  = mul_ofl_s;
    fin_divz_s = 1'b0;
`ifdef ALU_MC_DIV_EN
    if (is_div_r) begin
      fin_out_s  = div_fin_s;
      fin_ofl_s  = dofl_r & ~dz_r;
      fin_divz_s = dz_r;
    end else begin
      fin_out_s  = mul_fin_s[N-1:0];
      fin_ofl_s  = mul_ofl_s;
      fin_divz_s = 1'b0;
    end
`endif
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = S_IDLE;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) state_nxt_s = multi_s ? S_RUN : S_DONE;
        else       state_nxt_s = S_IDLE;
      end
      S_RUN: begin
        if (cnt_r == {LW{1'b0}}) state_nxt_s = S_DONE;
        else                     state_nxt_s = S_RUN;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register
  always_comb begin
    busy = (state_r == S_RUN);
    done = (state_r == S_DONE);
  end

  // Datapath: operand capture, iteration and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r    <= {N{1'b0}};
      ofl_r    <= 1'b0;
      cout_r   <= 1'b0;
      divz_r   <= 1'b0;
      cnt_r    <= {LW{1'b0}};
      sign_r   <= 1'b0;
      neg_r    <= 1'b0;
      prod_r   <= {(2*N){1'b0}};
      mcand_r  <= {(2*N){1'b0}};
      mplier_r <= {N{1'b0}};
`ifdef ALU_MC_DIV_EN
      quo_r    <= {N{1'b0}};
      rem_r    <= {N{1'b0}};
      dvs_r    <= {N{1'b0}};
      is_div_r <= 1'b0;
      dz_r     <= 1'b0;
      dofl_r   <= 1'b0;
`endif
    end else if (accept_s) begin
      if (multi_s) begin
        cnt_r    <= LW'(N-1);
        sign_r   <= sign;
        neg_r    <= a_neg_s ^ b_neg_s;
        prod_r   <= {(2*N){1'b0}};
        mcand_r  <= {{N{1'b0}}, mag_a_s};
        mplier_r <= mag_b_s;
`ifdef ALU_MC_DIV_EN
        quo_r    <= mag_a_s;
        rem_r    <= {N{1'b0}};
        dvs_r    <= mag_b_s;
        is_div_r <= is_div_s;
        dz_r     <= (InB == {N{1'b0}});
        // Most-negative / -1 is the only signed quotient that overflows
        dofl_r   <= sign & (a_s == {1'b1, {(N-1){1'b0}}}) & (InB == {N{1'b1}});
`endif
      end else begin
        out_r  <= sc_out_s;
        ofl_r  <= sc_ofl_s;
        cout_r <= sc_cout_s;
        divz_r <= 1'b0;
      end
    end else if (state_r == S_RUN) begin
      cnt_r    <= cnt_r - LW'(1'b1);
      prod_r   <= prod_nxt_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
`ifdef ALU_MC_DIV_EN
      rem_r    <= rem_nxt_s;
      quo_r    <= quo_nxt_s;
`endif
      if (cnt_r == {LW{1'b0}}) begin
        out_r  <= fin_out_s;
        ofl_r  <= fin_ofl_s;
        cout_r <= 1'b0;
        divz_r <= fin_divz_s;
      end
    end
  end

  assign Out  = out_r;
  assign Ofl  = ofl_r;
  assign Cout = cout_r;
  assign DivZ = divz_r;
  assign Zero = (out_r == {N{1'b0}});

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (N=16): directed vectors, expected results
// queued at issue time and checked by a monitor on every done pulse.
module tb_alu_mc;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst, start, Cin, invA, invB, sign, slbi;
  logic [N-1:0] InA, InB;
  logic [2:0]   Op;
  logic         busy, done, Zero, Ofl, Cout, DivZ;
  logic [N-1:0] Out;

  alu_mc #(.N(N), .O(3)) dut (
    .clk(clk), .rst(rst), .start(start), .InA(InA), .InB(InB), .Cin(Cin),
    .Op(Op), .invA(invA), .invB(invB), .sign(sign), .slbi(slbi),
    .busy(busy), .done(done), .Out(Out), .Zero(Zero), .Ofl(Ofl),
    .Cout(Cout), .DivZ(DivZ)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           id;
    logic [N-1:0] out;
    logic         ofl;
    logic         cout;
    logic         divz;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] last_exp = 16'h0000;

  task automatic chk(string name, int id, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s (op %0d) actual=%h required=%h", name, id, act, req);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest queued result
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out",  e.id, {16'h0000, Out}, {16'h0000, e.out});
        chk("zero", e.id, {31'd0, Zero}, {31'd0, (e.out == 16'h0000)});
        chk("ofl",  e.id, {31'd0, Ofl},  {31'd0, e.ofl});
        chk("cout", e.id, {31'd0, Cout}, {31'd0, e.cout});
        chk("divz", e.id, {31'd0, DivZ}, {31'd0, e.divz});
        chk("busy_with_done", e.id, {31'd0, busy}, 32'd0);
      end
    end
  end

  // Issue one op at the current negedge; optionally poke start or reset mid-run
  task automatic run_op(input int id, input logic [2:0] op,
                        input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic ci, input logic ia, input logic ib,
                        input logic sg, input logic sl,
                        input logic [N-1:0] eo, input logic eofl,
                        input logic ecout, input logic edivz,
                        input int elat, input int poke_c, input int rst_c);
    exp_t e;
    int   c, bc;
    bit   seen;
    Op = op; InA = a; InB = b; Cin = ci; invA = ia; invB = ib;
    sign = sg; slbi = sl; start = 1'b1;
    e.id = id; e.out = eo; e.ofl = eofl; e.cout = ecout; e.divz = edivz;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    c = 0; bc = 0; seen = 1'b0;
    while (!seen && c < 100) begin
      @(negedge clk);
      c++;
      if (start) start = 1'b0;
      if (busy) bc++;
      if (done) seen = 1'b1;
      else if (c == poke_c) begin
        chk("hold_during_run", id, {16'h0000, Out}, {16'h0000, last_exp});
        start = 1'b1; InA = 16'h1111; InB = 16'h2222; Op = 3'b000;
      end else if (c == rst_c) begin
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        void'(sb.pop_back());
        last_exp = 16'h0000;
        return;
      end
    end
    chk("latency", id, c, elat);
    chk("busy_cycles", id, bc, elat - 1);
    last_exp = eo;
  endtask

  initial begin
    int dcnt;
    rst = 1'b1; start = 1'b0; InA = 16'h0000; InB = 16'h0000; Cin = 1'b0;
    Op = 3'b000; invA = 1'b0; invB = 1'b0; sign = 1'b0; slbi = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 0, {31'd0, busy}, 32'd0);
    chk("rst_done", 0, {31'd0, done}, 32'd0);
    chk("rst_out",  0, {16'h0000, Out}, 32'd0);
    chk("rst_zero", 0, {31'd0, Zero}, 32'd1);
    chk("rst_ofl",  0, {31'd0, Ofl},  32'd0);
    chk("rst_cout", 0, {31'd0, Cout}, 32'd0);
    chk("rst_divz", 0, {31'd0, DivZ}, 32'd0);

    //     id op      A         B         ci ia ib sg sl exp_out  ofl cout dz lat
    run_op( 1, 3'b000, 16'h7FFF, 16'h0001, 0, 0, 0, 1, 0, 16'h8000, 1, 0, 0, 1, 0, 0);
    run_op( 2, 3'b000, 16'hFFFF, 16'h0001, 0, 0, 0, 0, 0, 16'h0000, 1, 1, 0, 1, 0, 0);
    run_op( 3, 3'b000, 16'h0005, 16'h0003, 1, 0, 1, 1, 0, 16'h0002, 0, 1, 0, 1, 0, 0);
    run_op( 4, 3'b001, 16'hF0F0, 16'h3C3C, 0, 0, 0, 0, 0, 16'h3030, 0, 0, 0, 1, 0, 0);
    run_op( 5, 3'b011, 16'h00FF, 16'h0F0F, 0, 1, 0, 0, 0, 16'hF00F, 0, 0, 0, 1, 0, 0);
    run_op( 6, 3'b010, 16'h00AB, 16'h00CD, 0, 0, 0, 0, 1, 16'hABCD, 0, 0, 0, 1, 0, 0);
    run_op( 7, 3'b101, 16'h8000, 16'h0004, 0, 0, 0, 1, 0, 16'hF800, 0, 0, 0, 1, 0, 0);
    run_op( 8, 3'b101, 16'h8000, 16'h0004, 0, 0, 0, 0, 0, 16'h0800, 0, 0, 0, 1, 0, 0);
    run_op( 9, 3'b100, 16'h0001, 16'h001F, 0, 0, 0, 0, 0, 16'h8000, 0, 0, 0, 1, 0, 0);
    run_op(10, 3'b110, 16'h0012, 16'h0034, 0, 0, 0, 0, 0, 16'h03A8, 0, 0, 0, 17, 0, 0);
    run_op(11, 3'b110, 16'hFFFD, 16'h0004, 0, 0, 0, 1, 0, 16'hFFF4, 0, 0, 0, 17, 0, 0);
    run_op(12, 3'b110, 16'h0100, 16'h0100, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 17, 0, 0);
    run_op(13, 3'b110, 16'h8000, 16'hFFFF, 0, 0, 0, 1, 0, 16'h8000, 1, 0, 0, 17, 0, 0);
    run_op(14, 3'b110, 16'hFFFF, 16'hFFFF, 0, 0, 0, 1, 0, 16'h0001, 0, 0, 0, 17, 0, 0);
`ifdef ALU_MC_DIV_EN
    run_op(15, 3'b111, 16'd100,  16'd7,    0, 0, 0, 0, 0, 16'h000E, 0, 0, 0, 17, 0, 0);
    run_op(16, 3'b111, 16'h1234, 16'h0000, 0, 0, 0, 0, 0, 16'hFFFF, 0, 0, 1, 17, 0, 0);
    run_op(17, 3'b111, 16'h8000, 16'hFFFF, 0, 0, 0, 1, 0, 16'h8000, 1, 0, 0, 17, 0, 0);
    run_op(18, 3'b111, 16'hFFF9, 16'h0002, 0, 0, 0, 1, 0, 16'hFFFD, 0, 0, 0, 17, 0, 0);
`else
    run_op(15, 3'b111, 16'd100,  16'd7,    0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 0);
    run_op(16, 3'b111, 16'h1234, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 0);
`endif
    run_op(19, 3'b000, 16'h1000, 16'h0234, 0, 0, 0, 0, 0, 16'h1234, 0, 0, 0, 1, 0, 0);
    // Result holds after the FSM returns to IDLE
    @(negedge clk);
    chk("idle_done", 19, {31'd0, done}, 32'd0);
    chk("idle_hold", 19, {16'h0000, Out}, {16'h0000, last_exp});

    // start during RUN is ignored; the original product is delivered
    run_op(20, 3'b110, 16'h0007, 16'h0009, 0, 0, 0, 0, 0, 16'h003F, 0, 0, 0, 17, 3, 0);

    // Reset during RUN aborts with no done
    run_op(21, 3'b110, 16'h0003, 16'h0005, 0, 0, 0, 0, 0, 16'h000F, 0, 0, 0, 17, 0, 5);
    @(negedge clk);
    chk("abort_busy", 21, {31'd0, busy}, 32'd0);
    chk("abort_done", 21, {31'd0, done}, 32'd0);
    chk("abort_out",  21, {16'h0000, Out}, 32'd0);
    chk("abort_zero", 21, {31'd0, Zero}, 32'd1);
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", 21, dcnt, 0);

    // rst and start together: request dropped
    Op = 3'b000; InA = 16'h0001; InB = 16'h0001; start = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1 begin rst = 1'b0; start = 1'b0; end
    @(negedge clk);
    chk("rst_start_done", 22, {31'd0, done}, 32'd0);
    chk("rst_start_busy", 22, {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("rst_start_done2", 22, {31'd0, done}, 32'd0);

    run_op(23, 3'b000, 16'h0001, 16'h0001, 0, 0, 0, 0, 0, 16'h0002, 0, 0, 0, 1, 0, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 0, sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the execute stage. Generalises the single-cycle ALU to width `N` and adds an iterative shift-add multiplier and a restoring divider, both behind a start/busy/done handshake. All results are registered. The decode/hazard logic stalls the pipeline while `busy` is high.

## Interface
- `N`, 16: datapath width; must be a power of two, ≥ 8.
- `O`, 3: opcode width.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous reset, active high.
- `start` input 1: operation request; sampled only in IDLE or DONE.
- `InA` input N: operand A.
- `InB` input N: operand B.
- `Cin` input 1: carry-in, ADD only.
- `Op` input O: operation select.
- `invA` input 1: invert A, applies to ADD/AND/OR/XOR only.
- `invB` input 1: invert B, applies to ADD/AND/OR/XOR only.
- `sign` input 1: signed (1) or unsigned (0) interpretation.
- `slbi` input 1: A operand replaced by `InA << (N/2)`.
- `busy` output 1: iterative operation in progress.
- `done` output 1: one-cycle result-valid pulse.
- `Out` output N: registered result.
- `Zero` output 1: `Out == 0`, decoded from the `Out` register.
- `Ofl` output 1: overflow.
- `Cout` output 1: ADD carry-out, 0 for every other op.
- `DivZ` output 1: divide-by-zero flag.

## Operation
- Op encoding:
  - 000 ADD; 001 AND; 010 OR; 011 XOR.
  - 100 SLL; 101 SRL (arithmetic when `sign=1`). Shift amount is `InB[log2(N)-1:0]`.
  - 110 MUL; 111 DIV.
- Operands, opcode and mode bits are captured at the accepting edge. Later input changes have no effect on the operation in flight.
- ADD `Ofl`: signed overflow when `sign=1`, carry-out when `sign=0`.
- Logic ops and shifts: `Ofl = 0`.
- MUL: N-step shift-add on magnitudes; the product is negated if `sign=1` and the operand signs differ.
  - `Out` = low N bits of the product.
  - `Ofl` = product does not fit in N bits (signed or unsigned range according to `sign`).
- DIV: N-step restoring division on magnitudes; the quotient truncates toward zero.
  - `sign=1`, `InA` = most-negative value, `InB` = -1: `Out = InA`, `Ofl = 1`.
  - `InB = 0`: `Out` all ones, `DivZ = 1`, `Ofl = 0`. The operation still takes the full latency.
- FSM states:
  - IDLE: `start` leads to DONE for single-cycle ops and to RUN for MUL/DIV.
  - RUN: an iteration counter runs N−1 down to 0; at 0 the FSM goes to DONE.
  - DONE: `start` is accepted exactly as in IDLE (back-to-back issue); otherwise the FSM returns to IDLE.
- `start` during RUN is ignored. No request is queued.
- `Out`, `Ofl`, `Cout` and `DivZ` hold their value from one `done` to the next. During RUN only internal registers change.

## Timing
- Let the accepting edge be edge 0.
- Single-cycle ops: `done = 1` and outputs are valid in the cycle following edge 0 (latency 1).
- MUL/DIV:
  - `busy = 1` in the N cycles following edges 0..N−1.
  - `done = 1` in the cycle following edge N (latency N+1).
- `busy = (state == RUN)` and `done = (state == DONE)`. They are never high together.
- Reset values: state IDLE, `busy = 0`, `done = 0`, `Out = 0`, `Zero = 1`, `Ofl = 0`, `Cout = 0`, `DivZ = 0`.
- `rst` during RUN aborts the operation. The reset values appear in the cycle after the reset edge, and no `done` is produced for the aborted operation.
- `rst` and `start` in the same cycle: `rst` wins and the request is dropped.

## Configuration
- `ALU_MC_DIV_EN` defined: the divider datapath is built and DIV behaves as specified above.
- `ALU_MC_DIV_EN` undefined: no divider logic is built. Op 111 completes as a single-cycle op with `Out = 0`, `Ofl = 1` and `DivZ = 0`. The decoder treats it as an illegal op.

## Test plan
- ADD, `sign=1`, `InA=0x7FFF`, `InB=0x0001`, `Cin=0` → `Out=0x8000`, `Ofl=1`, `Cout=0`, `done` one cycle after start, `busy` never high.
- MUL, `sign=0`, `0x0012 × 0x0034` → `busy` for 16 cycles, `done` in cycle 17, `Out=0x03A8`, `Ofl=0`. Then back-to-back MUL, `sign=1`, `0xFFFD × 0x0004` → `Out=0xFFF4`, `Ofl=0`.
- DIV, `sign=0`, `100 / 7` → `Out=0x000E` in cycle 17. DIV `0x1234 / 0` → `Out=0xFFFF`, `DivZ=1`. DIV, `sign=1`, `0x8000 / 0xFFFF` → `Out=0x8000`, `Ofl=1`.
- MUL started, `start` pulsed again at cycle 3 with new operands → ignored, and the original result is delivered. `rst` asserted at cycle 5 of another MUL → next cycle `busy=0`, `Out=0`, `Zero=1`, and no `done`.
- `slbi=1`, Op OR, `InA=0x00AB`, `InB=0x00CD` → `Out=0xABCD`. SRL, `sign=1`, `InA=0x8000`, `InB=0x0004` → `Out=0xF800`.
- `ALU_MC_DIV_EN` undefined: DIV `100 / 7` → `done` after 1 cycle, `Out=0`, `Ofl=1`.
